// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: instruction fetch front end for a synchronous instruction ROM.
// Keeps one read outstanding toward the ROM and buffers returned words in a
// 2-entry {pc, instr} FIFO. A redirect flushes the FIFO and the outstanding read.
// Optional build macro IFETCH_ALIGN_CHECK_EN: when defined, a redirect to a
// non-word-aligned target sets the sticky misalign_err flag. Misaligned targets
// are always word-aligned before use, whether or not the macro is defined.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [9:0]  imem_addr,
  input  logic [31:0] imem_dout,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        misalign_err
);

  logic [31:0] fetch_pc;
  logic        inflight;
  logic [31:0] inflight_pc;

  logic [1:0]  count;
  logic [31:0] head_pc, head_instr;
  logic [31:0] tail_pc, tail_instr;

  logic        pop, push, issue;
  logic [2:0]  occupancy;
  logic [31:0] target_pc, issue_pc;

  // Issue decision: keep FIFO entries plus outstanding reads at or below two.
  always_comb begin
    target_pc = redirect_pc & 32'hFFFF_FFFC;
    pop       = (count != 2'd0) & ~redirect & instr_ready;
    push      = inflight & ~redirect;
    occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    issue     = redirect | (occupancy <= 3'd1);
    issue_pc  = redirect ? target_pc : fetch_pc;
  end

  assign imem_addr   = issue_pc[11:2];
  assign instr_valid = (count != 2'd0) & ~redirect;
  assign instr       = head_instr;
  assign instr_pc    = head_pc;

  // Fetch pointer and the single outstanding ROM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= issue_pc;
        fetch_pc    <= issue_pc + 32'd4;
      end
    end
  end

  // Two-entry FIFO; the head register drives the outputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= 2'd0;
      head_pc    <= 32'h0;
      head_instr <= 32'h0;
      tail_pc    <= 32'h0;
      tail_instr <= 32'h0;
    end else if (redirect) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_pc    <= inflight_pc;
            head_instr <= imem_dout;
          end else begin
            tail_pc    <= inflight_pc;
            tail_instr <= imem_dout;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_pc    <= tail_pc;
          head_instr <= tail_instr;
          count      <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_pc    <= inflight_pc;
            head_instr <= imem_dout;
          end else begin
            head_pc    <= tail_pc;
            head_instr <= tail_instr;
            tail_pc    <= inflight_pc;
            tail_instr <= imem_dout;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  // Sticky flag for redirects whose target is not word aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      misalign_err <= 1'b0;
    else if (redirect && (redirect_pc[1:0] != 2'b00))
      misalign_err <= 1'b1;
  end
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  imem_addr;
  logic [31:0] imem_dout;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misalign_err;

  int total = 0;
  int bad   = 0;

`ifdef IFETCH_ALIGN_CHECK_EN
  localparam logic MIS = 1'b1;
`else
  localparam logic MIS = 1'b0;
`endif

  instr_fetch_ctrl #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_dout(imem_dout),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // ROM model: word k holds the value k, one-cycle registered read.
  always @(posedge clk) imem_dout <= {22'h0, imem_addr};

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        rdy;
    logic        v;
    logic [9:0]  addr;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        err;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(logic rd, logic [31:0] rpc, logic rdy, logic v,
                              logic [9:0] addr, logic [31:0] ins, logic [31:0] pc,
                              logic err);
    vec_t t;
    t.rd = rd; t.rpc = rpc; t.rdy = rdy; t.v = v;
    t.addr = addr; t.ins = ins; t.pc = pc; t.err = err;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // cycles counted from reset release; rows: rd, rpc, rdy | v, addr, instr, pc, err
    vecs[0]  = mk(0, 0, 1,      0, 0,    0, 0, 0);
    vecs[1]  = mk(0, 0, 1,      0, 1,    0, 0, 0);
    vecs[2]  = mk(0, 0, 0,      1, 2,    0, 0, 0);
    vecs[3]  = mk(0, 0, 0,      1, 2,    0, 0, 0);
    vecs[4]  = mk(0, 0, 0,      1, 2,    0, 0, 0);
    vecs[5]  = mk(0, 0, 0,      1, 2,    0, 0, 0);
    vecs[6]  = mk(0, 0, 0,      1, 2,    0, 0, 0);
    vecs[7]  = mk(0, 0, 1,      1, 2,    0, 0, 0);
    vecs[8]  = mk(0, 0, 1,      1, 3,    1, 4, 0);
    vecs[9]  = mk(0, 0, 1,      1, 4,    2, 8, 0);
    vecs[10] = mk(0, 0, 1,      1, 5,    3, 12, 0);
    vecs[11] = mk(0, 0, 0,      1, 6,    4, 16, 0);
    vecs[12] = mk(0, 0, 0,      1, 6,    4, 16, 0);
    vecs[13] = mk(1, 32'h100, 1, 0, 64,  0, 0, 0);
    vecs[14] = mk(0, 0, 1,      0, 65,   0, 0, 0);
    vecs[15] = mk(0, 0, 1,      1, 66,   64, 32'h100, 0);
    vecs[16] = mk(0, 0, 1,      1, 67,   65, 32'h104, 0);
    vecs[17] = mk(1, 32'h102, 1, 0, 64,  0, 0, 0);
    vecs[18] = mk(0, 0, 1,      0, 65,   0, 0, MIS);
    vecs[19] = mk(0, 0, 1,      1, 66,   64, 32'h100, MIS);
    vecs[20] = mk(1, 32'hFFC, 1, 0, 1023, 0, 0, MIS);
    vecs[21] = mk(0, 0, 1,      0, 0,    0, 0, MIS);
    vecs[22] = mk(0, 0, 1,      1, 1,    1023, 32'hFFC, MIS);
    vecs[23] = mk(0, 0, 1,      1, 2,    0, 32'h1000, MIS);
    vecs[24] = mk(0, 0, 1,      1, 3,    1, 32'h1004, MIS);

    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_addr", {22'h0, imem_addr}, 32'h0);
    chk("rst_err", {31'h0, misalign_err}, 32'h0);

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      redirect = vecs[i].rd; redirect_pc = vecs[i].rpc; instr_ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].v});
      chk($sformatf("v%0d_addr", i), {22'h0, imem_addr}, {22'h0, vecs[i].addr});
      chk($sformatf("v%0d_err", i), {31'h0, misalign_err}, {31'h0, vecs[i].err});
      if (vecs[i].v) begin
        chk($sformatf("v%0d_instr", i), instr, vecs[i].ins);
        chk($sformatf("v%0d_pc", i), instr_pc, vecs[i].pc);
      end
    end

    // Asynchronous reset in the middle of a stream, then restart.
    @(negedge clk);
    redirect = 1'b0; instr_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("mid_rst_instr", instr, 32'h0);
    chk("mid_rst_pc", instr_pc, 32'h0);
    chk("mid_rst_addr", {22'h0, imem_addr}, 32'h0);
    chk("mid_rst_err", {31'h0, misalign_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("restart_addr0", {22'h0, imem_addr}, 32'h0);
    begin
      int n;
      n = 0;
      while (!instr_valid && n < 6) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("restart_latency", n, 2);
      chk("restart_instr0", instr, 32'h0);
      chk("restart_pc0", instr_pc, 32'h0);
      @(negedge clk);
      #1;
      chk("restart_instr1", instr, 32'h1);
      chk("restart_pc1", instr_pc, 32'h4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
